fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the MIPS pipeline: owns the program counter, drives the word address into the combinational instruction memory, and registers the returned word into the IF/ID pipeline register for decode. Handles stall, flush, branch redirect, and a halt condition (halt word fetched or end of memory reached). Sits directly upstream of the instruction memory and directly feeds the decode stage.

## Interface
- MEM_DEPTH, 128: instruction-memory depth in words; legal PCs are 0..MEM_DEPTH-1.
- HALT_WORD, 32'hFC000000: instruction encoding that stops fetch once captured.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hold PC and IF/ID register (hazard unit).
- flush  in  1  squash the IF/ID entry (insert bubble).
- branch_taken  in  1  redirect fetch to branch_target this cycle.
- branch_target  in  32  word address of the redirect target.
- imem_addr  out  32  word index to instruction memory; combinational copy of the PC register.
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- ifid_instr  out  32  registered instruction to decode.
- ifid_pc1  out  32  registered PC+1 of that instruction.
- ifid_valid  out  1  ifid_instr is a real instruction (0 = bubble).
- halted  out  1  FSM is in HALT.
- fetch_count  out  16  number of instructions captured valid since reset.

## Operation
- Addressing is word-indexed: sequential next PC = PC+1 (not +4). 32-bit unsigned arithmetic.
- FSM states: RUN, HALT. Reset -> RUN.
- Per-cycle priority for next state (highest first): rst, branch_taken, flush, stall, FSM.
- rst: PC=0, ifid_instr=0, ifid_pc1=0, ifid_valid=0, fetch_count=0, state RUN. halted=0.
- branch_taken (any state, overrides stall and flush): PC<=branch_target; IF/ID<=bubble (instr 0, pc1 0, valid 0). If branch_target < MEM_DEPTH state<=RUN, else state<=HALT and PC<=MEM_DEPTH-1.
- flush without branch: IF/ID<=bubble; PC advances per RUN/HALT rules below (flush does not hold PC).
- stall (no branch, no flush): PC, IF/ID, state, fetch_count all hold.
- RUN, no stall/flush/branch: ifid_instr<=imem_data, ifid_pc1<=PC+1, ifid_valid<=1, fetch_count+=1 (saturates at 16'hFFFF).
  - If imem_data == HALT_WORD: word is still captured valid; state<=HALT; PC holds.
  - Else if PC == MEM_DEPTH-1: state<=HALT; PC holds at MEM_DEPTH-1.
  - Else PC<=PC+1.
- HALT, no branch: PC holds; IF/ID<=bubble each cycle; fetch_count holds. Only rst or branch_taken leaves HALT.
- imem_addr always < MEM_DEPTH after reset except transiently never: PC is never loaded with an out-of-range value.
- Bubble encoding: ifid_instr=32'h00000000 (NOP), ifid_pc1=0, ifid_valid=0.

## Timing
- imem_addr changes on the clock edge that updates PC; imem_data is sampled at the next edge. Instruction at address A appears on ifid_instr one cycle after PC==A.
- First valid output: cycle 1 after rst deasserts (instruction 0 captured at the first edge with rst=0).
- Branch penalty: cycle with branch_taken produces a bubble; target instruction valid on ifid_* one cycle later (assuming no stall).
- stall for N cycles extends all outputs by exactly N cycles; no instruction lost or duplicated.
- rst mid-operation overrides stall/branch/flush in the same cycle; all outputs at reset values after that edge.
- halted asserts the edge after the halting instruction is captured, same edge that presents it as valid.

## Test plan
- Reset then run with memory 0..8 = 002300AA,10654321,00200022,8C123456,8F123456,AD654321,13012345,AC654321,12012345 -> ifid_instr follows that order on consecutive cycles, ifid_pc1=1..9, fetch_count=9 after 9 cycles.
- Stall held 3 cycles while PC=4 -> ifid_instr stays 8C123456, imem_addr stays 4, then 8F123456 next; no skip/duplicate.
- branch_taken with target 2 at PC=6 (stall also high) -> next cycle ifid_valid=0, following cycle ifid_instr=00200022, ifid_pc1=3.
- Place HALT_WORD at address 3 -> FC000000 captured valid, halted=1, then ifid_valid=0 indefinitely, fetch_count frozen at 4; branch to 0 resumes.
- Run to PC=MEM_DEPTH-1 (127) -> last word captured, halted=1, imem_addr stays 127; branch to 200 -> HALT, PC 127.
- Assert rst during a stall at PC=5 -> next cycle PC=0, all IF/ID outputs 0, fetch_count=0, halted=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives word addresses into the
// combinational instruction memory and registers the fetched word for decode.
module fetch_stage #(
   parameter int unsigned MEM_DEPTH = 128,
   parameter logic [31:0] HALT_WORD = 32'hFC000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc1,
   output logic        ifid_valid,
   output logic        halted,
   output logic [15:0] fetch_count
);

   typedef enum logic {RUN, HALT} state_t;

   localparam logic [31:0] LAST_PC = 32'(MEM_DEPTH - 1);
   localparam logic [31:0] DEPTH   = 32'(MEM_DEPTH);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc1_q, pc1_d;
   logic        valid_q, valid_d;
   logic [15:0] cnt_q, cnt_d;

   logic        tgt_ok;
   logic        is_halt;
   logic        at_end;

   assign tgt_ok  = branch_target < DEPTH;
   assign is_halt = imem_data == HALT_WORD;
   assign at_end  = pc_q == LAST_PC;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= '0;
         instr_q <= '0;
         pc1_q   <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc1_q   <= pc1_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: branch beats flush beats stall beats normal FSM flow.
   always_comb begin
      state_d = state_q;
      if (branch_taken) begin
         state_d = tgt_ok ? RUN : HALT;
      end else if (flush) begin
         if (state_q == RUN && at_end)
            state_d = HALT;
      end else if (!stall) begin
         if (state_q == RUN && (is_halt || at_end))
            state_d = HALT;
      end
   end

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pc1_d   = pc1_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (branch_taken) begin
         pc_d    = tgt_ok ? branch_target : LAST_PC;
         instr_d = '0;
         pc1_d   = '0;
         valid_d = 1'b0;
      end else if (flush) begin
         instr_d = '0;
         pc1_d   = '0;
         valid_d = 1'b0;
         if (state_q == RUN && !at_end)
            pc_d = pc_q + 32'd1;
      end else if (!stall) begin
         if (state_q == RUN) begin
            instr_d = imem_data;
            pc1_d   = pc_q + 32'd1;
            valid_d = 1'b1;
            if (cnt_q != 16'hFFFF)
               cnt_d = cnt_q + 16'd1;
            if (!is_halt && !at_end)
               pc_d = pc_q + 32'd1;
         end else begin
            instr_d = '0;
            pc1_d   = '0;
            valid_d = 1'b0;
         end
      end
   end

   always_comb begin
      halted      = state_q == HALT;
      imem_addr   = pc_q;
      ifid_instr  = instr_q;
      ifid_pc1    = pc1_q;
      ifid_valid  = valid_q;
      fetch_count = cnt_q;
   end

endmodule
